// File: rtl/seq_control_gen_pkg.sv
// Shared types and helpers for the compare-and-store sequencer: state
// encoding, control-word field layout and the control-word packer.
package seq_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CHECK = 3'd2,
    ST_WR0   = 3'd3,
    ST_WR1   = 3'd4,
    ST_DONE  = 3'd5,
    ST_HALT  = 3'd6
  } state_t;

  // Widest control word the packer can build; callers cast down to their width.
  localparam int CW_MAX = 64;

  // Field layout, LSB first: we, reg_sel, sel_b, sel_a, alu_op.
  localparam int WE_OFS = 0;
  localparam int RS_OFS = 1;

  function automatic int sbOffset(input int regW);
    return RS_OFS + regW;
  endfunction

  function automatic int saOffset(input int regW, input int selW);
    return RS_OFS + regW + selW;
  endfunction

  function automatic int aluOffset(input int regW, input int selW);
    return RS_OFS + regW + 2 * selW;
  endfunction

  // Builds {alu, sa, sb, rs, we}; each field is masked to its width so that
  // select arithmetic wraps modulo 2^width instead of spilling into neighbours.
  function automatic logic [CW_MAX-1:0] pack_cw(
    input logic [31:0] alu,
    input logic [31:0] sa,
    input logic [31:0] sb,
    input logic [31:0] rs,
    input logic        we,
    input int          aluW,
    input int          selW,
    input int          regW
  );
    logic [CW_MAX-1:0] mAlu;
    logic [CW_MAX-1:0] mSel;
    logic [CW_MAX-1:0] mReg;
    mAlu = (64'd1 << aluW) - 64'd1;
    mSel = (64'd1 << selW) - 64'd1;
    mReg = (64'd1 << regW) - 64'd1;
    return ((CW_MAX'(alu) & mAlu) << aluOffset(regW, selW))
         | ((CW_MAX'(sa)  & mSel) << saOffset(regW, selW))
         | ((CW_MAX'(sb)  & mSel) << sbOffset(regW))
         | ((CW_MAX'(rs)  & mReg) << RS_OFS)
         | (CW_MAX'(we) << WE_OFS);
  endfunction

endpackage

// File: rtl/seq_control_gen_if.sv
// Handshake and status bundle between the sequencer and whoever drives it.
// Signal names are from the sequencer's point of view.
interface seq_control_gen_if #(
  parameter int ALU_W   = 4,
  parameter int SEL_W   = 4,
  parameter int REG_W   = 3,
  parameter int PASS_W  = 8,
  parameter int N_STEPS = 3
);
  localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int CW_W   = ALU_W + 2 * SEL_W + REG_W + 1;

  logic              i_start;
  logic              i_abort;
  logic              i_mayor;
  logic [CW_W-1:0]   o_signal;
  logic              o_busy;
  logic              o_done;
  logic              o_found;
  logic [STEP_W-1:0] o_step;
  logic [PASS_W-1:0] o_pass;

  modport master (
    output i_start, i_abort, i_mayor,
    input  o_signal, o_busy, o_done, o_found, o_step, o_pass
  );

  modport slave (
    input  i_start, i_abort, i_mayor,
    output o_signal, o_busy, o_done, o_found, o_step, o_pass
  );
endinterface

// File: rtl/seq_control_gen_step_counter.sv
// Step index k (wraps at N_STEPS) and completed-pass counter for the sequencer.
// Clear wins over advance; both are frozen when neither is asserted.
module seq_step_counter #(
  parameter int N_STEPS    = 3,
  parameter int STEP_W     = 2,
  parameter int PASS_W     = 8,
  parameter int MAX_PASSES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [STEP_W-1:0] o_step,
  output logic [PASS_W-1:0] o_pass,
  output logic              o_lastStep,
  output logic              o_passLimit
);

  logic [STEP_W-1:0] r_step;
  logic [PASS_W-1:0] r_pass;
  logic [PASS_W-1:0] w_passNext;
  logic              w_lastStep;

  assign w_lastStep = (r_step == STEP_W'(N_STEPS - 1));
  assign w_passNext = r_pass + 1'b1;

  // Step/pass registers: cleared on reset or clear, stepped once per finished step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_step <= '0;
      r_pass <= '0;
    end else if (i_clear) begin
      r_step <= '0;
      r_pass <= '0;
    end else if (i_advance) begin
      if (w_lastStep) begin
        r_step <= '0;
        r_pass <= w_passNext;
      end else begin
        r_step <= r_step + 1'b1;
      end
    end
  end

  assign o_step      = r_step;
  assign o_pass      = r_pass;
  assign o_lastStep  = w_lastStep;
  assign o_passLimit = (MAX_PASSES != 0) && (w_passNext == PASS_W'(MAX_PASSES));

endmodule

// File: rtl/seq_control_gen.sv
// Moore sequencer stepping the datapath through a ring of compare-and-store
// steps: present operands, sample the greater flag, then halt or write twice.
module seq_control_gen
  import seq_control_pkg::*;
#(
  parameter int N_STEPS    = 3,
  parameter int ALU_W      = 4,
  parameter int SEL_W      = 4,
  parameter int REG_W      = 3,
  parameter int SEL_BASE   = 2,
  parameter int SEL_STRIDE = 2,
  parameter int TMP_REG    = 4,
  parameter int ALU_OP_CMP = 0,
  parameter int PASS_W     = 8,
  parameter int MAX_PASSES = 0
) (
  input logic              clk,
  input logic              rst,
  seq_control_gen_if.slave bus
);

  localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int CW_W   = ALU_W + 2 * SEL_W + REG_W + 1;

  state_t            r_state;
  state_t            w_nextState;
  logic              w_clear;
  logic              w_advance;
  logic [STEP_W-1:0] w_step;
  logic [PASS_W-1:0] w_pass;
  logic              w_lastStep;
  logic              w_passLimit;
  logic [SEL_W-1:0]  w_selA;
  logic [SEL_W-1:0]  w_selB;
  logic [CW_W-1:0]   w_signal;

  seq_step_counter #(
    .N_STEPS   (N_STEPS),
    .STEP_W    (STEP_W),
    .PASS_W    (PASS_W),
    .MAX_PASSES(MAX_PASSES)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .o_step     (w_step),
    .o_pass     (w_pass),
    .o_lastStep (w_lastStep),
    .o_passLimit(w_passLimit)
  );

  // State register; reset returns to IDLE regardless of any other input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus counter clear/advance; abort outranks everything outside IDLE.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (bus.i_start && !bus.i_abort) begin
        w_nextState = ST_SETUP;
        w_clear     = 1'b1;
      end
    end else if (bus.i_abort) begin
      w_nextState = ST_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_SETUP: w_nextState = ST_CHECK;
        ST_CHECK: w_nextState = bus.i_mayor ? ST_HALT : ST_WR0;
        ST_WR0:   w_nextState = ST_WR1;
        ST_WR1: begin
          w_advance   = 1'b1;
          w_nextState = (w_lastStep && w_passLimit) ? ST_DONE : ST_SETUP;
        end
        ST_DONE, ST_HALT: begin
          if (bus.i_start) begin
            w_nextState = ST_SETUP;
            w_clear     = 1'b1;
          end
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  // Operand selects for step k; the last step wraps its B operand back to step 0's A.
  always_comb begin
    w_selA = SEL_W'(32'(SEL_BASE) + 32'(SEL_STRIDE) * 32'(w_step));
    w_selB = w_lastStep ? SEL_W'(SEL_BASE)
                        : SEL_W'(32'(SEL_BASE) + 32'(SEL_STRIDE) * (32'(w_step) + 32'd1));
  end

  // Control-word decode from registered state and step only.
  always_comb begin
    w_signal = '0;
    case (r_state)
      ST_SETUP, ST_CHECK:
        w_signal = CW_W'(pack_cw(32'(ALU_OP_CMP), 32'(w_selA), 32'(w_selB), 32'd0, 1'b0,
                                 ALU_W, SEL_W, REG_W));
      ST_WR0:
        w_signal = CW_W'(pack_cw(32'd0, 32'(w_selA), 32'(w_selB), 32'(TMP_REG), 1'b1,
                                 ALU_W, SEL_W, REG_W));
      ST_WR1:
        w_signal = CW_W'(pack_cw(32'd0, 32'(w_selA), 32'(w_selB), 32'(w_step) + 32'd1, 1'b1,
                                 ALU_W, SEL_W, REG_W));
      default: w_signal = '0;
    endcase
  end

  assign bus.o_signal = w_signal;
  assign bus.o_busy   = (r_state == ST_SETUP) || (r_state == ST_CHECK) ||
                        (r_state == ST_WR0)   || (r_state == ST_WR1);
  assign bus.o_done   = (r_state == ST_DONE) || (r_state == ST_HALT);
  assign bus.o_found  = (r_state == ST_HALT);
  assign bus.o_step   = w_step;
  assign bus.o_pass   = w_pass;

endmodule

// File: tb/tb_seq_control_gen.sv
// Directed bench for seq_control_gen: a 3-step instance limited to two passes
// and a 5-step unlimited instance with a 2-bit pass counter.
module tb_seq_control_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectorCount = 0;
  int   failCount   = 0;

  seq_control_gen_if #(.PASS_W(8), .N_STEPS(3)) busA ();
  seq_control_gen_if #(.PASS_W(2), .N_STEPS(5)) busB ();

  seq_control_gen #(.MAX_PASSES(2)) dutA (
    .clk(clk),
    .rst(rst),
    .bus(busA)
  );

  seq_control_gen #(
    .N_STEPS   (5),
    .SEL_BASE  (1),
    .SEL_STRIDE(3),
    .PASS_W    (2),
    .MAX_PASSES(0)
  ) dutB (
    .clk(clk),
    .rst(rst),
    .bus(busB)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One full pass of the 3-step instance, cycle by cycle: SETUP, CHECK, WR0, WR1 per step.
  logic [15:0] passTableA [12] = '{
    16'h0240, 16'h0240, 16'h0249, 16'h0243,
    16'h0460, 16'h0460, 16'h0469, 16'h0465,
    16'h0620, 16'h0620, 16'h0629, 16'h0627
  };

  // SETUP words of the 5-step instance: sel_a = 1,4,7,10,13 and sel_b = next sel_a.
  logic [15:0] setupTableB [5] = '{16'h0140, 16'h0470, 16'h07A0, 16'h0AD0, 16'h0D10};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic start, input logic abort,
                               input logic mayor);
    if (toB) begin
      busB.i_start = start;
      busB.i_abort = abort;
      busB.i_mayor = mayor;
    end else begin
      busA.i_start = start;
      busA.i_abort = abort;
      busA.i_mayor = mayor;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    busA.i_start = 1'b0; busA.i_abort = 1'b0; busA.i_mayor = 1'b0;
    busB.i_start = 1'b0; busB.i_abort = 1'b0; busB.i_mayor = 1'b0;

    // Reset, then idle with no start.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_signal", 32'(busA.o_signal), 32'h0);
    checkOutput("rst_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("rst_done",   32'(busA.o_done),   32'h0);
    checkOutput("rst_found",  32'(busA.o_found),  32'h0);
    checkOutput("rst_step",   32'(busA.o_step),   32'h0);
    checkOutput("rst_pass",   32'(busA.o_pass),   32'h0);
    checkOutput("rstB_signal", 32'(busB.o_signal), 32'h0);

    // Two full passes without a halt, then DONE.
    $display("[TB] two-pass run to DONE");
    applyStimulus(0, 1, 0, 0);
    for (int c = 0; c < 24; c++) begin
      checkOutput("run_signal", 32'(busA.o_signal), 32'(passTableA[c % 12]));
      checkOutput("run_step",   32'(busA.o_step),   32'((c % 12) / 4));
      checkOutput("run_pass",   32'(busA.o_pass),   32'(c / 12));
      checkOutput("run_busy",   32'(busA.o_busy),   32'h1);
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("done_done",   32'(busA.o_done),   32'h1);
    checkOutput("done_found",  32'(busA.o_found),  32'h0);
    checkOutput("done_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("done_pass",   32'(busA.o_pass),   32'h2);
    checkOutput("done_step",   32'(busA.o_step),   32'h0);
    checkOutput("done_signal", 32'(busA.o_signal), 32'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("done_hold", 32'(busA.o_done), 32'h1);
    checkOutput("done_holdpass", 32'(busA.o_pass), 32'h2);

    // Restart, halt on the greater flag in CHECK of step 1.
    $display("[TB] halt in step 1");
    applyStimulus(0, 1, 0, 0);
    checkOutput("restart_pass",   32'(busA.o_pass),   32'h0);
    checkOutput("restart_signal", 32'(busA.o_signal), 32'h0240);
    repeat (5) applyStimulus(0, 0, 0, 0);
    checkOutput("chk1_signal", 32'(busA.o_signal), 32'h0460);
    applyStimulus(0, 0, 0, 1);
    checkOutput("halt_found",  32'(busA.o_found),  32'h1);
    checkOutput("halt_done",   32'(busA.o_done),   32'h1);
    checkOutput("halt_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("halt_step",   32'(busA.o_step),   32'h1);
    checkOutput("halt_signal", 32'(busA.o_signal), 32'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("halt_hold_found",  32'(busA.o_found),  32'h1);
    checkOutput("halt_hold_signal", 32'(busA.o_signal), 32'h0);
    checkOutput("halt_hold_step",   32'(busA.o_step),   32'h1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("rehalt_found",  32'(busA.o_found),  32'h0);
    checkOutput("rehalt_step",   32'(busA.o_step),   32'h0);
    checkOutput("rehalt_pass",   32'(busA.o_pass),   32'h0);
    checkOutput("rehalt_signal", 32'(busA.o_signal), 32'h0240);

    // Greater-flag pulses everywhere except CHECK, then abort in WR0 of step 2, pass 1.
    $display("[TB] flag noise and abort");
    for (int c = 0; c < 22; c++) begin
      applyStimulus(0, 0, 0, (c % 4) != 1);
      checkOutput("noise_found", 32'(busA.o_found), 32'h0);
      checkOutput("noise_busy",  32'(busA.o_busy),  32'h1);
    end
    checkOutput("wr0_signal", 32'(busA.o_signal), 32'h0629);
    checkOutput("wr0_pass",   32'(busA.o_pass),   32'h1);
    checkOutput("wr0_step",   32'(busA.o_step),   32'h2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("abort_signal", 32'(busA.o_signal), 32'h0);
    checkOutput("abort_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("abort_done",   32'(busA.o_done),   32'h0);
    checkOutput("abort_step",   32'(busA.o_step),   32'h0);
    checkOutput("abort_pass",   32'(busA.o_pass),   32'h0);

    // Reset in CHECK with the flag high, then start and abort together in IDLE.
    $display("[TB] reset in CHECK and start with abort");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre_rst_signal", 32'(busA.o_signal), 32'h0240);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst_found",  32'(busA.o_found),  32'h0);
    checkOutput("midrst_done",   32'(busA.o_done),   32'h0);
    checkOutput("midrst_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("midrst_signal", 32'(busA.o_signal), 32'h0);
    rst = 1'b1;
    applyStimulus(0, 1, 1, 0);
    checkOutput("startabort_busy",   32'(busA.o_busy),   32'h0);
    checkOutput("startabort_signal", 32'(busA.o_signal), 32'h0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("start_after_busy", 32'(busA.o_busy), 32'h1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("final_abort_busy", 32'(busA.o_busy), 32'h0);

    // Five-step ring with unlimited passes: pass counter wraps 3 -> 0, never DONE.
    $display("[TB] five-step ring with pass wrap");
    applyStimulus(1, 1, 0, 0);
    for (int c = 0; c < 80; c++) begin
      if ((c % 4) == 0)
        checkOutput("ringB_setup", 32'(busB.o_signal), 32'(setupTableB[(c / 4) % 5]));
      if ((c % 20) == 19)
        checkOutput("ringB_wr1_last", 32'(busB.o_signal), 32'h0D1B);
      checkOutput("ringB_pass", 32'(busB.o_pass), 32'((c / 20) % 4));
      checkOutput("ringB_done", 32'(busB.o_done), 32'h0);
      applyStimulus(1, 0, 0, 0);
    end
    checkOutput("wrapB_pass",   32'(busB.o_pass),   32'h0);
    checkOutput("wrapB_busy",   32'(busB.o_busy),   32'h1);
    checkOutput("wrapB_step",   32'(busB.o_step),   32'h0);
    checkOutput("wrapB_signal", 32'(busB.o_signal), 32'h0140);
    applyStimulus(1, 0, 1, 0);
    checkOutput("abortB_busy", 32'(busB.o_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
